// File: rtl/nes_pkg.sv
// nes_pkg: shared types and constants for the NES gamepad poller.
//   state_e      - frame sequencer states
//   BTN_*        - bit positions of each button in the button word
//   NUM_BUTTONS  - width of the button word
package nes_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_HI,
    CLK_LO,
    DONE
  } state_e;

endpackage

// File: rtl/nes_in_sync.sv
// nes_in_sync: two-flop synchronizer for an asynchronous 1-bit input.
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input
//   q_o     - synchronized output (RST_VAL while in reset)
module nes_in_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= {2{RST_VAL}};
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: drives the latch/clock waveform of a 4021-based NES pad,
// shifts in 8 active-low button bits and publishes an active-high word.
//   ACLK, ARESETN   - clock, asynchronous active-low reset
//   enable          - periodic polling every POLL_INTERVAL_CYC cycles
//   poll_req        - one-cycle software poll request
//   nes_data        - pad serial data (active-low, asynchronous)
//   nes_latch       - pad latch strobe (registered)
//   nes_clk         - pad shift clock, idles low (registered)
//   buttons         - active-high word, bit0..7 = A,B,Select,Start,Up,Down,Left,Right
//   buttons_valid   - one-cycle pulse when buttons updates
//   changed         - one-cycle pulse with buttons_valid when the word changed
//   busy            - a frame is in progress
// Optional (NES_CHANGE_IRQ_EN defined): irq (sticky on changed), irq_ack.
module nes_pad_poller
  import nes_pkg::*;
#(
  parameter int LATCH_CYC         = 600,
  parameter int HALF_CYC          = 300,
  parameter int POLL_INTERVAL_CYC = 833333
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   enable,
  input  logic                   poll_req,
  input  logic                   nes_data,
  output logic                   nes_latch,
  output logic                   nes_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   buttons_valid,
  output logic                   changed,
`ifdef NES_CHANGE_IRQ_EN
  output logic                   irq,
  input  logic                   irq_ack,
`endif
  output logic                   busy
);

  localparam int TMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam int CW   = $clog2(POLL_INTERVAL_CYC);

  logic                   din_s;
  logic [CW-1:0]          cnt_q;
  logic                   tick;
  logic                   pend_q;
  logic                   start;
  state_e                 state_q;
  logic [TW-1:0]          tmr_q;
  logic [2:0]             bit_idx_q;
  logic [NUM_BUTTONS-1:0] shift_q;
  logic [NUM_BUTTONS-1:0] shift_fin;

  nes_in_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .d_i    (nes_data),
    .q_o    (din_s)
  );

  // Interval counter: free-runs only while enabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                           cnt_q <= '0;
    else if (!enable)                       cnt_q <= '0;
    else if (cnt_q == CW'(POLL_INTERVAL_CYC - 1)) cnt_q <= '0;
    else                                    cnt_q <= cnt_q + CW'(1);
  end

  assign tick  = enable && (cnt_q == CW'(POLL_INTERVAL_CYC - 1));
  assign start = tick || poll_req || pend_q;

  // Requests seen mid-frame collapse into a single follow-up frame.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 pend_q <= 1'b0;
    else if (state_q == IDLE)     pend_q <= 1'b0;
    else if (tick || poll_req)    pend_q <= 1'b1;
  end

  // Word as it will be once the final (bit7) sample lands this cycle.
  assign shift_fin = {din_s, shift_q[NUM_BUTTONS-2:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      nes_latch     <= 1'b0;
      nes_clk       <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      changed       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      buttons_valid <= 1'b0;
      changed       <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= LATCH;
          tmr_q     <= TW'(LATCH_CYC - 1);
          nes_latch <= 1'b1;
          busy      <= 1'b1;
        end
        LATCH: if (tmr_q == '0) begin
          state_q   <= GAP;
          tmr_q     <= TW'(HALF_CYC - 1);
          nes_latch <= 1'b0;
        end else tmr_q <= tmr_q - TW'(1);
        GAP: if (tmr_q == '0) begin
          // Bit0 (A) is on the pin as soon as the latch drops.
          shift_q[BTN_A] <= din_s;
          bit_idx_q      <= 3'(BTN_B);
          state_q        <= CLK_HI;
          tmr_q          <= TW'(HALF_CYC - 1);
          nes_clk        <= 1'b1;
        end else tmr_q <= tmr_q - TW'(1);
        CLK_HI: if (tmr_q == '0) begin
          state_q <= CLK_LO;
          tmr_q   <= TW'(HALF_CYC - 1);
          nes_clk <= 1'b0;
        end else tmr_q <= tmr_q - TW'(1);
        CLK_LO: if (tmr_q == '0) begin
          shift_q[bit_idx_q] <= din_s;
          if (bit_idx_q == 3'(BTN_RIGHT)) begin
            state_q       <= DONE;
            buttons       <= ~shift_fin;
            buttons_valid <= 1'b1;
            changed       <= (~shift_fin != buttons);
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
            state_q   <= CLK_HI;
            tmr_q     <= TW'(HALF_CYC - 1);
            nes_clk   <= 1'b1;
          end
        end else tmr_q <= tmr_q - TW'(1);
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          nes_latch <= 1'b0;
          nes_clk   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef NES_CHANGE_IRQ_EN
  // Sticky change flag; a new change beats a coincident acknowledge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)     irq <= 1'b0;
    else if (changed) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_nes_pad_poller.sv
module tb_nes_pad_poller;
  localparam int L  = 8;
  localparam int H  = 4;
  localparam int P  = 200;
  localparam int DONE_OFF = L + 15 * H;   // offset of the valid cycle (frame = 69 cycles)

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       enable = 1'b0;
  logic       poll_req = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk, buttons_valid, changed, busy;
  logic [7:0] buttons;
`ifdef NES_CHANGE_IRQ_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  nes_pad_poller #(.LATCH_CYC(L), .HALF_CYC(H), .POLL_INTERVAL_CYC(P)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .poll_req(poll_req),
    .nes_data(nes_data), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .buttons(buttons), .buttons_valid(buttons_valid), .changed(changed),
`ifdef NES_CHANGE_IRQ_EN
    .irq(irq), .irq_ack(irq_ack),
`endif
    .busy(busy));

  // 4021 pad: parallel load on latch, shift on clk rising edge, serial-in = 1.
  logic [7:0] pad = 8'h00;
  logic [7:0] pad_sr = 8'hFF;
  always @(posedge nes_latch or posedge nes_clk)
    if (nes_latch) pad_sr <= ~pad;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  assign nes_data = pad_sr[0];

  // Reference model: position within the current frame (-1 = idle).
  int         m_off = -1;
  int         m_cnt = 0;
  int         m_nx;
  logic       m_pend = 1'b0;
  logic       m_tick, m_req;
  logic [7:0] m_pat = 8'h00;
  logic [7:0] m_btn = 8'h00;
  logic       m_chg = 1'b0;
  logic       m_irq = 1'b0;

  always_comb begin
    m_tick = enable && (m_cnt == P - 1);
    m_req  = poll_req || m_tick;
    if (m_off < 0)              m_nx = (m_req || m_pend) ? 0 : -1;
    else if (m_off == DONE_OFF) m_nx = -1;
    else                        m_nx = m_off + 1;
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_off <= -1; m_cnt <= 0; m_pend <= 1'b0; m_btn <= 8'h00; m_chg <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_cnt <= (!enable || m_cnt == P - 1) ? 0 : m_cnt + 1;
      m_off <= m_nx;
      if (m_off < 0)  m_pend <= 1'b0;
      else if (m_req) m_pend <= 1'b1;
      if (m_nx == 0) m_pat <= pad;
      if (m_nx == DONE_OFF) begin
        m_chg <= (m_pat != m_btn);
        m_btn <= m_pat;
      end else m_chg <= 1'b0;
`ifdef NES_CHANGE_IRQ_EN
      if (m_chg)        m_irq <= 1'b1;
      else if (irq_ack) m_irq <= 1'b0;
`endif
    end
  end

  logic       e_latch, e_clk, e_busy, e_valid;
  always_comb begin
    e_latch = (m_off >= 0) && (m_off < L);
    e_clk   = (m_off >= L + H) && (m_off < DONE_OFF) && ((((m_off - L - H) / H) % 2) == 0);
    e_busy  = (m_off >= 0);
    e_valid = (m_off == DONE_OFF);
  end

  // Per-cycle compare against the model.
  always @(negedge ACLK) begin
    logic [13:0] act, exp;
    act = {nes_latch, nes_clk, busy, buttons_valid, changed, buttons, 1'b0};
    exp = {e_latch, e_clk, e_busy, e_valid, m_chg, m_btn, 1'b0};
`ifdef NES_CHANGE_IRQ_EN
    act[0] = irq;
    exp[0] = m_irq;
`endif
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL cycle_compare cyc=%0d {latch,clk,busy,valid,chg,buttons,irq} got=%h expected=%h",
               cyc, act, exp);
    end
  end

  // Event counters used by the directed checks.
  int   n_lrise = 0, n_crise = 0, n_lhi = 0, n_chi = 0, n_val = 0, n_chg = 0;
  int   t_rise = 0, t_prev_rise = 0, t_val = 0;
  logic p_latch = 1'b0, p_clk = 1'b0;
  always @(negedge ACLK) begin
    if (nes_latch && !p_latch) begin n_lrise <= n_lrise + 1; t_prev_rise <= t_rise; t_rise <= cyc; end
    if (nes_clk && !p_clk) n_crise <= n_crise + 1;
    if (nes_latch) n_lhi <= n_lhi + 1;
    if (nes_clk)   n_chi <= n_chi + 1;
    if (buttons_valid) begin n_val <= n_val + 1; t_val <= cyc; end
    if (changed)   n_chg <= n_chg + 1;
    p_latch <= nes_latch;
    p_clk   <= nes_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic poll();
    poll_req = 1'b1;
    step(1);
    poll_req = 1'b0;
  endtask

  int s_lrise, s_crise, s_lhi, s_chi, s_val, s_chg;
  task automatic snap();
    #1;   // let the negedge counters settle
    s_lrise = n_lrise; s_crise = n_crise; s_lhi = n_lhi; s_chi = n_chi; s_val = n_val; s_chg = n_chg;
  endtask

  initial begin
    int k;
    // Reset and idle
    step(5);
    chk("reset_buttons", buttons, 8'h00);
    chk("reset_busy", busy, 1'b0);
    ARESETN = 1'b1;
    snap();
    step(500);
    chk("idle_no_latch", n_lrise - s_lrise, 0);
    chk("idle_buttons", buttons, 8'h00);

    // Single poll, pattern 0x5A
    pad = 8'h5A;
    snap();
    poll();
    step(80);
    chk("poll1_latch_cycles", n_lhi - s_lhi, L);
    chk("poll1_clk_pulses", n_crise - s_crise, 7);
    chk("poll1_clk_high_cycles", n_chi - s_chi, 7 * H);
    chk("poll1_frame_len", t_val - t_rise + 1, 69);
    chk("poll1_valid", n_val - s_val, 1);
    chk("poll1_changed", n_chg - s_chg, 1);
    chk("poll1_buttons", buttons, 8'h5A);

    // Same pattern again: no change
    snap();
    poll();
    step(80);
    chk("poll2_valid", n_val - s_val, 1);
    chk("poll2_changed", n_chg - s_chg, 0);
    chk("poll2_buttons", buttons, 8'h5A);

    // Periodic polling
    pad = 8'h81;
    enable = 1'b1;
    snap();
    step(650);
    chk("periodic_frames", n_lrise - s_lrise, 3);
    chk("periodic_buttons", buttons, 8'h81);
    snap();
    k = 0;
    while (n_lrise == s_lrise && k < 300) begin step(1); k++; end
    chk("periodic_next_frame_seen", (k < 300), 1'b1);
    step(20);
    enable = 1'b0;
    snap();
    step(400);
    chk("disable_frame_completes", n_val - s_val, 1);
    chk("disable_no_more_frames", n_lrise - s_lrise, 0);

    // Request collision: three requests during one frame -> one extra frame
    pad = 8'h3C;
    snap();
    poll();
    step(10); poll();
    step(10); poll();
    step(10); poll();
    step(200);
    chk("collide_frames", n_lrise - s_lrise, 2);
    chk("collide_valids", n_val - s_val, 2);
    chk("collide_changed", n_chg - s_chg, 1);
    chk("collide_restart_gap", t_rise - t_prev_rise, 70);
    chk("collide_buttons", buttons, 8'h3C);

    // Reset in CLK_HI
    pad = 8'h66;
    poll();
    k = 0;
    while (!nes_clk && k < 100) begin step(1); k++; end
    chk("midreset_clk_seen", nes_clk, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    chk("midreset_clk_async", nes_clk, 1'b0);
    chk("midreset_latch_async", nes_latch, 1'b0);
    chk("midreset_busy_async", busy, 1'b0);
    step(3);
    ARESETN = 1'b1;
    step(50);
    chk("after_reset_buttons", buttons, 8'h00);
    chk("after_reset_busy", busy, 1'b0);

`ifdef NES_CHANGE_IRQ_EN
    pad = 8'h00;
    poll(); step(80);
    chk("irq_no_change", irq, 1'b0);
    pad = 8'h01;
    poll(); step(80);
    chk("irq_set", irq, 1'b1);
    step(20);
    chk("irq_held", irq, 1'b1);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    chk("irq_acked", irq, 1'b0);
    pad = 8'h02;
    poll();
    k = 0;
    while (!buttons_valid && k < 100) begin @(negedge ACLK); k++; end
    chk("irq_valid_seen", buttons_valid, 1'b1);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("irq_set_beats_ack", irq, 1'b1);
    step(5);
    chk("irq_still_set", irq, 1'b1);
    chk("irq_buttons", buttons, 8'h02);
`endif

    step(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nes_pad_poller.md
Name: nes_pad_poller

Overview:
- Sequences the serial NES gamepad (4021 shift register) behind the NES AXI4-Lite peripheral.
- Periodically or on request, generates the latch and clock waveform and shifts in 8 button bits.
- Presents a stable, active-high button word that the AXI register block reads.
- Sits between the AXI slave register file and the pad pins, in the ACLK domain.

Parameters:
- LATCH_CYC, 600: ACLK cycles that nes_latch is held high (12 us at 50 MHz).
- HALF_CYC, 300: ACLK cycles per nes_clk half-period and per post-latch gap. Must be >= 3.
- POLL_INTERVAL_CYC, 833333: ACLK cycles between automatic polls (about 60 Hz at 50 MHz).

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous, active-low reset
- enable  in  1  1 = automatic periodic polling enabled
- poll_req  in  1  single-cycle software poll request
- nes_data  in  1  pad serial data, active-low, asynchronous
- nes_latch  out  1  pad latch strobe
- nes_clk  out  1  pad shift clock; idles low
- buttons  out  8  active-high, bit0..7 = A, B, Select, Start, Up, Down, Left, Right
- buttons_valid  out  1  one-cycle pulse when buttons updates
- changed  out  1  one-cycle pulse coincident with buttons_valid when the new word differs from the old
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, ACLK; reset is asynchronous and active-low, ARESETN.
- Reset values: all outputs 0; state IDLE; interval counter 0; pending flag 0; shift register 0. Assertion mid-frame aborts immediately; nes_latch and nes_clk drop asynchronously.
- Input sync: nes_data passes through a 2-flop synchronizer that resets to 1 (released/not pressed).
- Interval counter:
  - Counts only while enable=1. Cleared while enable=0.
  - At POLL_INTERVAL_CYC-1 it wraps to 0 and raises a tick.
- Frame start:
  - In IDLE, a frame starts on the next cycle when tick, poll_req or pending is high.
  - poll_req or tick arriving while busy sets pending, which is cleared at frame start. Multiple requests collapse into one.
  - poll_req and tick in the same cycle start one frame.
- FSM:
  - IDLE -> LATCH: LATCH_CYC cycles, nes_latch=1.
  - LATCH -> GAP: HALF_CYC cycles, both pins low. Sample bit0 on the last GAP cycle.
  - GAP -> CLK_HI: HALF_CYC cycles, nes_clk=1.
  - CLK_HI -> CLK_LO: HALF_CYC cycles, nes_clk=0. Sample bit k on the last cycle.
  - CLK_HI/CLK_LO repeats for k = 1..7 (3-bit index, no wrap past 7).
  - After bit7 -> DONE: 1 cycle. Then DONE -> IDLE.
- Output timing:
  - nes_latch and nes_clk are registered outputs, glitch-free.
  - Frame length from the first nes_latch high cycle to the buttons_valid cycle is LATCH_CYC + 15*HALF_CYC + 1 cycles.
- DONE cycle:
  - buttons <= ~sampled bits.
  - buttons_valid=1.
  - changed=1 only if the new value differs from the previous buttons.
- Enable mid-frame: enable dropping mid-frame does not abort the frame. Only automatic ticks stop.
- Phase timing: a single down-counter times every phase. It is loaded on each state entry and the state advances when it reaches 0.

Optional Feature:
- Macro: NES_CHANGE_IRQ_EN.
- When defined:
  - Adds port irq (out, 1) and irq_ack (in, 1).
  - irq is set on a changed pulse and held until irq_ack.
  - If set and ack occur in the same cycle, set wins.
  - Reset value is 0.
- When undefined: these ports and their logic are absent; changed is the only notification.

Decomposition:
- Package nes_pkg holds:
  - the FSM state enum (IDLE, LATCH, GAP, CLK_HI, CLK_LO, DONE);
  - button bit index constants BTN_A..BTN_RIGHT;
  - NUM_BUTTONS = 8.
- One sub-module, nes_in_sync: a 2-flop synchronizer with reset value as a parameter.

Test Plan:
- Use LATCH_CYC=8, HALF_CYC=4, POLL_INTERVAL_CYC=200. The frame length is 69 cycles.
- Reset and idle: hold ARESETN low, then release with enable=0 and no poll_req for 500 cycles -> nes_latch, nes_clk, busy, buttons_valid stay 0; buttons=0x00.
- Single poll: pad model drives serial pattern 0x5A active-low, poll_req for 1 cycle -> nes_latch high for 8 cycles, 7 nes_clk pulses 4 cycles wide, buttons_valid 69 cycles after the first latch cycle, buttons=0x5A, changed=1.
- Repeat the poll with the same pattern -> buttons=0x5A, buttons_valid=1, changed=0.
- Periodic polling: enable=1 -> frame starts every 200 cycles. Drop enable mid-frame -> that frame completes and no further frames start.
- Request collision: poll_req three times during a frame -> exactly one extra frame starts immediately after DONE.
- Reset mid-frame: assert ARESETN in CLK_HI -> nes_clk and nes_latch go to 0 asynchronously and busy=0. After release, buttons=0x00 until the next poll.
- With NES_CHANGE_IRQ_EN defined:
  - Pattern change 0x00 -> 0x01 -> irq=1, held until irq_ack.
  - irq_ack coincident with a new change -> irq stays 1.
